// File: rtl/zx_kbd_pkg.sv
// Shared types and constants for the ZX Spectrum PS/2 keyboard front end:
// receiver states, PS/2 prefix bytes, key source indices and matrix geometry.
package zx_kbd_pkg;

    // PS/2 frame receiver states
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Scan-code set 2 prefix / control bytes
    localparam logic [7:0] CODE_EXT   = 8'hE0;  // extended key prefix
    localparam logic [7:0] CODE_BRK   = 8'hF0;  // key release prefix
    localparam logic [7:0] CODE_PAUSE = 8'hE1;  // Pause sequence lead-in
    localparam logic [7:0] CODE_BAT   = 8'hAA;  // self-test passed / reconnect

    // Bytes dropped after the Pause lead-in
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Matrix geometry: 8 half-rows of 5 keys, bit0 is the outermost key
    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 5;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int NUM_SRC  = NUM_KEYS + 6;

    // Key sources. The first 40 are matrix positions (row*5 + col); the rest
    // are composite PC keys that each press two matrix keys.
    typedef enum logic [5:0] {
        K_CAPS, K_Z, K_X, K_C, K_V,          // half-row 0
        K_A, K_S, K_D, K_F, K_G,             // half-row 1
        K_Q, K_W, K_E, K_R, K_T,             // half-row 2
        K_1, K_2, K_3, K_4, K_5,             // half-row 3
        K_0, K_9, K_8, K_7, K_6,             // half-row 4
        K_P, K_O, K_I, K_U, K_Y,             // half-row 5
        K_ENTER, K_L, K_K, K_J, K_H,         // half-row 6
        K_SPACE, K_SYM, K_M, K_N, K_B,       // half-row 7
        S_BKSP,                              // CAPS SHIFT + 0
        S_LEFT,                              // CAPS SHIFT + 5
        S_DOWN,                              // CAPS SHIFT + 6
        S_UP,                                // CAPS SHIFT + 7
        S_RIGHT,                             // CAPS SHIFT + 8
        S_RSHIFT                             // CAPS SHIFT (right shift)
    } key_src_e;

endpackage

// File: rtl/zx_ps2_keymap.sv
// Combinational lookup from {extended flag, scan code} to a key source.
// Unmapped codes report hit = 0 and must be ignored by the caller.
module zx_ps2_keymap
    import zx_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output key_src_e   src
);

    // Scan-code set 2 table; arrows only exist behind the E0 prefix
    always_comb begin
        hit = 1'b1;
        src = K_CAPS;
        case ({ext, code})
            9'h012: src = K_CAPS;      // left shift
            9'h059: src = S_RSHIFT;    // right shift
            9'h014: src = K_SYM;       // ctrl
            9'h05A: src = K_ENTER;
            9'h029: src = K_SPACE;
            9'h066: src = S_BKSP;      // backspace
            9'h16B: src = S_LEFT;
            9'h172: src = S_DOWN;
            9'h175: src = S_UP;
            9'h174: src = S_RIGHT;
            9'h01C: src = K_A;
            9'h032: src = K_B;
            9'h021: src = K_C;
            9'h023: src = K_D;
            9'h024: src = K_E;
            9'h02B: src = K_F;
            9'h034: src = K_G;
            9'h033: src = K_H;
            9'h043: src = K_I;
            9'h03B: src = K_J;
            9'h042: src = K_K;
            9'h04B: src = K_L;
            9'h03A: src = K_M;
            9'h031: src = K_N;
            9'h044: src = K_O;
            9'h04D: src = K_P;
            9'h015: src = K_Q;
            9'h02D: src = K_R;
            9'h01B: src = K_S;
            9'h02C: src = K_T;
            9'h03C: src = K_U;
            9'h02A: src = K_V;
            9'h01D: src = K_W;
            9'h022: src = K_X;
            9'h035: src = K_Y;
            9'h01A: src = K_Z;
            9'h016: src = K_1;
            9'h01E: src = K_2;
            9'h026: src = K_3;
            9'h025: src = K_4;
            9'h02E: src = K_5;
            9'h036: src = K_6;
            9'h03D: src = K_7;
            9'h03E: src = K_8;
            9'h046: src = K_9;
            9'h045: src = K_0;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/zx_ps2_keyboard.sv
// PS/2 keyboard to ZX Spectrum key matrix. Receives set-2 frames, tracks
// make/break state per key source and answers ULA port reads combinationally.
module zx_ps2_keyboard
    import zx_kbd_pkg::*;
#(
    parameter int CLK_HZ     = 3500000,
    parameter int TIMEOUT_US = 2000
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic [7:0] row_sel,
    output logic [4:0] key_col,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    // Product taken in 64 bits: the default parameters overflow 32 bits
    localparam longint TO_PRODUCT     = longint'(CLK_HZ) * longint'(TIMEOUT_US);
    localparam int     TIMEOUT_CYCLES = int'((TO_PRODUCT + 64'sd999999) / 64'sd1000000);
    localparam int     TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            ps2_clk_meta_reg, ps2_clk_sync_reg;
    logic            ps2_dat_meta_reg, ps2_dat_sync_reg;
    logic [3:0]      clk_hist_reg;
    logic            ps2_fall;
    rx_state_e       state_reg;
    logic [2:0]      bit_cnt_reg;
    logic [7:0]      shift_reg;
    logic            parity_reg;
    logic [7:0]      scan_code_reg;
    logic            scan_valid_reg;
    logic            frame_err_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            rx_timeout;
    logic            ext_reg, brk_reg;
    logic [2:0]      skip_reg;
    logic [NUM_SRC-1:0]  src_reg;
    logic [NUM_KEYS-1:0] key_bits;
    logic            map_hit;
    key_src_e        map_src;

    // Two-stage synchronisers plus clock history; idle line level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_meta_reg <= 1'b1;
            ps2_clk_sync_reg <= 1'b1;
            ps2_dat_meta_reg <= 1'b1;
            ps2_dat_sync_reg <= 1'b1;
            clk_hist_reg     <= 4'hF;
        end else begin
            ps2_clk_meta_reg <= PS2_CLK;
            ps2_clk_sync_reg <= ps2_clk_meta_reg;
            ps2_dat_meta_reg <= PS2_DAT;
            ps2_dat_sync_reg <= ps2_dat_meta_reg;
            clk_hist_reg     <= {clk_hist_reg[2:0], ps2_clk_sync_reg};
        end
    end

    // Two highs followed by two lows: a clean falling edge, glitches rejected
    assign ps2_fall = (clk_hist_reg == 4'b1100);

    assign rx_timeout = (state_reg != RX_IDLE) && !ps2_fall && (to_cnt_reg == TO_LAST);

    // Watchdog counts cycles since the last falling edge while a frame is open
    always_ff @(posedge clk) begin
        if (reset || state_reg == RX_IDLE || ps2_fall) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end

    // Frame receiver: start, 8 data bits LSB first, odd parity, stop
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RX_IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            parity_reg     <= 1'b0;
            scan_code_reg  <= 8'h00;
            scan_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            scan_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (rx_timeout) begin
                state_reg     <= RX_IDLE;
                frame_err_reg <= 1'b1;
            end else if (ps2_fall) begin
                case (state_reg)
                    RX_IDLE: begin
                        // A high bit here is line noise, not a start bit
                        if (!ps2_dat_sync_reg) begin
                            state_reg   <= RX_DATA;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shift_reg   <= {ps2_dat_sync_reg, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_reg <= ps2_dat_sync_reg;
                        state_reg  <= RX_STOP;
                    end
                    RX_STOP: begin
                        state_reg <= RX_IDLE;
                        if (ps2_dat_sync_reg && (^{shift_reg, parity_reg})) begin
                            scan_code_reg  <= shift_reg;
                            scan_valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    zx_ps2_keymap u_keymap (
        .ext  (ext_reg),
        .code (scan_code_reg),
        .hit  (map_hit),
        .src  (map_src)
    );

    // Byte decoder: prefix tracking, Pause skipping and key source updates
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_reg  <= 1'b0;
            brk_reg  <= 1'b0;
            skip_reg <= 3'd0;
            src_reg  <= '0;
        end else if (rx_timeout) begin
            ext_reg  <= 1'b0;
            brk_reg  <= 1'b0;
            skip_reg <= 3'd0;
        end else if (scan_valid_reg) begin
            if (skip_reg != 3'd0) begin
                skip_reg <= skip_reg - 3'd1;
            end else if (scan_code_reg == CODE_EXT) begin
                ext_reg <= 1'b1;
            end else if (scan_code_reg == CODE_BRK) begin
                brk_reg <= 1'b1;
            end else if (scan_code_reg == CODE_PAUSE) begin
                skip_reg <= PAUSE_SKIP;
            end else if (scan_code_reg == CODE_BAT && !ext_reg && !brk_reg) begin
                src_reg <= '0;
            end else begin
                if (map_hit) begin
                    src_reg[map_src] <= !brk_reg;
                end
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    // Fold composite sources onto the matrix keys they press
    always_comb begin
        key_bits         = src_reg[NUM_KEYS-1:0];
        key_bits[K_CAPS] = src_reg[K_CAPS] | src_reg[S_BKSP] | src_reg[S_LEFT] |
                           src_reg[S_DOWN] | src_reg[S_UP] | src_reg[S_RIGHT] |
                           src_reg[S_RSHIFT];
        key_bits[K_0]    = src_reg[K_0] | src_reg[S_BKSP];
        key_bits[K_5]    = src_reg[K_5] | src_reg[S_LEFT];
        key_bits[K_6]    = src_reg[K_6] | src_reg[S_DOWN];
        key_bits[K_7]    = src_reg[K_7] | src_reg[S_UP];
        key_bits[K_8]    = src_reg[K_8] | src_reg[S_RIGHT];
    end

    // Column read: any pressed key in any selected half-row pulls the bit low
    genvar gi, gr;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
            logic [NUM_ROWS-1:0] col_bits;
            for (gr = 0; gr < NUM_ROWS; gr++) begin : g_row
                assign col_bits[gr] = key_bits[gr*NUM_COLS + gi];
            end
            assign key_col[gi] = ~|(col_bits & ~row_sel);
        end
    endgenerate

    assign scan_code  = scan_code_reg;
    assign scan_valid = scan_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_zx_ps2_keyboard.sv
// Bench for zx_ps2_keyboard: directed frames followed by random key traffic,
// compared against a model that tracks physical PC keys held down.
`timescale 1ns/1ps
module tb_zx_ps2_keyboard;

    localparam int HALF = 12;   // PS/2 half bit period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] row_sel = 8'hFF;
    logic [4:0] key_col;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    zx_ps2_keyboard #(.CLK_HZ(3500000), .TIMEOUT_US(2000)) dut (
        .clk        (clk),
        .reset      (reset),
        .PS2_CLK    (ps2_clk),
        .PS2_DAT    (ps2_dat),
        .row_sel    (row_sel),
        .key_col    (key_col),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sv_cnt = 0;
    int fe_cnt = 0;

    // Count output pulses away from the active edge
    always @(negedge clk) begin
        if (scan_valid) sv_cnt <= sv_cnt + 1;
        if (frame_err)  fe_cnt <= fe_cnt + 1;
    end

    // ---------------- reference model ----------------
    string layout [8][5] = '{
        '{"CAPS", "Z", "X", "C", "V"},
        '{"A", "S", "D", "F", "G"},
        '{"Q", "W", "E", "R", "T"},
        '{"1", "2", "3", "4", "5"},
        '{"0", "9", "8", "7", "6"},
        '{"P", "O", "I", "U", "Y"},
        '{"ENTER", "L", "K", "J", "H"},
        '{"SPACE", "SYM", "M", "N", "B"}
    };
    string nm1 [int];
    string nm2 [int];
    int    keys_q [$];
    int    pressed [int];
    bit    m_ext = 0;
    bit    m_brk = 0;
    int    m_skip = 0;

    task automatic add_key(input int k, input string a, input string b);
        nm1[k] = a;
        nm2[k] = b;
        keys_q.push_back(k);
    endtask

    task automatic init_tables();
        add_key(12'h012, "CAPS", "");  add_key(12'h059, "CAPS", "");
        add_key(12'h014, "SYM", "");   add_key(12'h05A, "ENTER", "");
        add_key(12'h029, "SPACE", ""); add_key(12'h066, "CAPS", "0");
        add_key(12'h16B, "CAPS", "5"); add_key(12'h172, "CAPS", "6");
        add_key(12'h175, "CAPS", "7"); add_key(12'h174, "CAPS", "8");
        add_key(12'h01C, "A", ""); add_key(12'h032, "B", ""); add_key(12'h021, "C", "");
        add_key(12'h023, "D", ""); add_key(12'h024, "E", ""); add_key(12'h02B, "F", "");
        add_key(12'h034, "G", ""); add_key(12'h033, "H", ""); add_key(12'h043, "I", "");
        add_key(12'h03B, "J", ""); add_key(12'h042, "K", ""); add_key(12'h04B, "L", "");
        add_key(12'h03A, "M", ""); add_key(12'h031, "N", ""); add_key(12'h044, "O", "");
        add_key(12'h04D, "P", ""); add_key(12'h015, "Q", ""); add_key(12'h02D, "R", "");
        add_key(12'h01B, "S", ""); add_key(12'h02C, "T", ""); add_key(12'h03C, "U", "");
        add_key(12'h02A, "V", ""); add_key(12'h01D, "W", ""); add_key(12'h022, "X", "");
        add_key(12'h035, "Y", ""); add_key(12'h01A, "Z", "");
        add_key(12'h016, "1", ""); add_key(12'h01E, "2", ""); add_key(12'h026, "3", "");
        add_key(12'h025, "4", ""); add_key(12'h02E, "5", ""); add_key(12'h036, "6", "");
        add_key(12'h03D, "7", ""); add_key(12'h03E, "8", ""); add_key(12'h046, "9", "");
        add_key(12'h045, "0", "");
    endtask

    function automatic logic [4:0] press_name(input logic [4:0] col, input string nm,
                                              input logic [7:0] rs);
        logic [4:0] c = col;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 5; k++)
                if (layout[r][k] == nm && !rs[r]) c[k] = 1'b0;
        return c;
    endfunction

    function automatic logic [4:0] exp_col(input logic [7:0] rs);
        logic [4:0] c = 5'b11111;
        foreach (pressed[k]) begin
            c = press_name(c, nm1[k], rs);
            if (nm2[k] != "") c = press_name(c, nm2[k], rs);
        end
        return c;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int k;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hAA && !m_ext && !m_brk) pressed.delete();
        else begin
            k = (m_ext ? 256 : 0) + int'(b);
            if (nm1.exists(k)) begin
                if (m_brk) pressed.delete(k);
                else pressed[k] = 1;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic d);
        ps2_dat = d;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        tick(HALF);
    endtask

    task automatic check_cols(input string tag, input logic [7:0] rs);
        row_sel = rs;
        #1;
        chk(tag, 32'(key_col), 32'(exp_col(rs)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int sv0 = sv_cnt;
        int fe0 = fe_cnt;
        send_raw(b, 1'b0);
        model_byte(b);
        chk("scan_valid_pulses", 32'(sv_cnt - sv0), 32'd1);
        chk("no_frame_err", 32'(fe_cnt - fe0), 32'd0);
        chk("scan_code", 32'(scan_code), 32'(b));
        row_sel = 8'h00;
        #1;
        $display("tx %02h scan_code=%02h key_col@00=%b", b, scan_code, key_col);
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv0, fe0, k;
        logic [7:0] rs;
        bit brk;
        init_tables();

        // Reset state
        tick(5);
        reset = 1'b0;
        tick(2);
        row_sel = 8'h00;
        #1;
        chk("reset_key_col", 32'(key_col), 32'h1F);
        chk("reset_scan_code", 32'(scan_code), 32'h00);
        chk("reset_scan_valid", 32'(scan_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);

        // Falling edge with data high in idle is ignored silently
        sv0 = sv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b1);
        tick(HALF);
        chk("stray_edge_err", 32'(fe_cnt - fe0), 32'd0);
        chk("stray_edge_valid", 32'(sv_cnt - sv0), 32'd0);

        // A make then break
        send_byte(8'h1C);
        check_cols("A_make_FD", 8'hFD);
        chk("A_make_literal", 32'(key_col), 32'b11110);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_cols("A_break_FD", 8'hFD);
        chk("A_break_literal", 32'(key_col), 32'b11111);

        // Up arrow and shared CAPS SHIFT
        send_byte(8'hE0);
        send_byte(8'h75);
        check_cols("up_FE", 8'hFE);
        check_cols("up_EF", 8'hEF);
        check_cols("up_EE", 8'hEE);
        chk("up_EE_literal", 32'(key_col), 32'b10110);
        send_byte(8'h12);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_cols("lshift_held_FE", 8'hFE);
        chk("lshift_held_literal", 32'(key_col), 32'b11110);
        check_cols("up_released_EF", 8'hEF);

        // Bad parity frame
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_raw(8'h1C, 1'b1);
        chk("parity_err_pulse", 32'(fe_cnt - fe0), 32'd1);
        chk("parity_no_valid", 32'(sv_cnt - sv0), 32'd0);
        check_cols("parity_cols", 8'h00);

        // Timeout mid-frame, then a clean Z
        send_byte(8'hF0);
        send_byte(8'h12);
        sv0 = sv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        tick(8000);
        m_ext = 0; m_brk = 0; m_skip = 0;
        chk("timeout_err_pulse", 32'(fe_cnt - fe0), 32'd1);
        chk("timeout_no_valid", 32'(sv_cnt - sv0), 32'd0);
        send_byte(8'h1A);
        check_cols("Z_FE", 8'hFE);
        chk("Z_FE_literal", 32'(key_col), 32'b11101);

        // Reset mid-frame with keys held
        send_byte(8'h1C);
        send_byte(8'h15);
        check_cols("AQ_held", 8'h00);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pressed.delete();
        m_ext = 0; m_brk = 0; m_skip = 0;
        tick(2);
        row_sel = 8'h00;
        #1;
        chk("midreset_key_col", 32'(key_col), 32'h1F);
        chk("midreset_scan_code", 32'(scan_code), 32'h00);
        tick(HALF);
        send_byte(8'h1C);
        check_cols("after_reset_A", 8'hFD);

        // Pause sequence is swallowed
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        check_cols("pause_all", 8'h00);
        chk("pause_literal", 32'(key_col), 32'h1F);
        send_byte(8'h1C);
        check_cols("pause_then_A", 8'hFD);
        check_cols("pause_no_sym", 8'h7F);

        // Self-test byte clears everything
        send_byte(8'h66);
        send_byte(8'h29);
        check_cols("bksp_space", 8'h00);
        send_byte(8'hAA);
        check_cols("bat_clear", 8'h00);
        chk("bat_literal", 32'(key_col), 32'h1F);

        // Random key traffic
        for (int it = 0; it < 30; it++) begin
            k = keys_q[$urandom_range(keys_q.size() - 1)];
            brk = ($urandom_range(9) < 4);
            if (it % 10 == 9) begin
                send_byte(8'hAA);
            end else begin
                if (k >= 256) send_byte(8'hE0);
                if (brk) send_byte(8'hF0);
                send_byte(8'(k));
            end
            rs = 8'($urandom_range(255));
            check_cols("rand_rows", rs);
            check_cols("rand_all", 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
